// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator with binary, gray, scan and breathe modes on two banks
module led_pattern_gen #(
    parameter int LED_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 24,
    parameter int PWM_WIDTH      = 8,
    parameter int INVERT_A       = 1
) (
    input  logic                 clk,
    input  logic                 btn_reset,
    input  logic [1:0]           mode,
    input  logic                 pause,
    output logic [LED_WIDTH-1:0] io_led_a,
    output logic [LED_WIDTH-1:0] io_led_b,
    output logic                 step_tick
);

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    localparam int                   POS_W   = (LED_WIDTH > 2) ? $clog2(LED_WIDTH) : 1;
    localparam logic [POS_W-1:0]     POS_MAX = POS_W'(LED_WIDTH - 1);
    localparam logic [LED_WIDTH-1:0] A_MASK  = (INVERT_A != 0) ? {LED_WIDTH{1'b1}} : {LED_WIDTH{1'b0}};

    logic [PRESCALE_WIDTH-1:0] prescaler;
    mode_t                     active_mode;
    mode_t                     req_mode;
    logic [LED_WIDTH-1:0]      cnt;
    logic [POS_W-1:0]          pos;
    logic                      scan_up;
    logic [PWM_WIDTH-1:0]      level;
    logic                      breathe_up;
    logic [PWM_WIDTH-1:0]      pwm_cnt;
    logic                      tick;
    logic                      tick_d1;
    logic [LED_WIDTH-1:0]      pattern;
    logic [LED_WIDTH-1:0]      pattern_rev;

    // A step happens on the last prescaler cycle, and only while running
    assign tick     = (&prescaler) & ~pause;
    assign req_mode = mode_t'(mode);

    // Prescaler, mode capture and per-mode pattern state; all frozen while paused
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            prescaler   <= '0;
            active_mode <= MODE_BINARY;
            cnt         <= '0;
            pos         <= '0;
            scan_up     <= 1'b1;
            level       <= '0;
            breathe_up  <= 1'b1;
        end else begin
            if (!pause) begin
                prescaler <= prescaler + PRESCALE_WIDTH'(1);
            end
            if (tick) begin
                active_mode <= req_mode;
                if (req_mode != active_mode) begin
                    // A new mode starts from its initial state rather than advancing
                    case (req_mode)
                        MODE_BINARY, MODE_GRAY: cnt <= '0;
                        MODE_SCAN: begin
                            pos     <= '0;
                            scan_up <= 1'b1;
                        end
                        default: begin
                            level      <= '0;
                            breathe_up <= 1'b1;
                        end
                    endcase
                end else begin
                    case (active_mode)
                        MODE_BINARY, MODE_GRAY: cnt <= cnt + LED_WIDTH'(1);
                        MODE_SCAN: begin
                            // Turn around at the ends so each end is lit once per sweep
                            if (scan_up) begin
                                if (pos == POS_MAX) begin
                                    scan_up <= 1'b0;
                                    pos     <= pos - POS_W'(1);
                                end else begin
                                    pos <= pos + POS_W'(1);
                                end
                            end else begin
                                if (pos == '0) begin
                                    scan_up <= 1'b1;
                                    pos     <= POS_W'(1);
                                end else begin
                                    pos <= pos - POS_W'(1);
                                end
                            end
                        end
                        default: begin
                            if (breathe_up) begin
                                if (level == {PWM_WIDTH{1'b1}}) begin
                                    breathe_up <= 1'b0;
                                    level      <= level - PWM_WIDTH'(1);
                                end else begin
                                    level <= level + PWM_WIDTH'(1);
                                end
                            end else begin
                                if (level == '0) begin
                                    breathe_up <= 1'b1;
                                    level      <= PWM_WIDTH'(1);
                                end else begin
                                    level <= level - PWM_WIDTH'(1);
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    // PWM carrier keeps running during pause so a frozen breathe level stays dimmed
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
        end
    end

    // Pattern decode from the active mode's state, plus the bank B bit reversal
    always_comb begin
        pattern     = '0;
        pattern_rev = '0;
        case (active_mode)
            MODE_BINARY: pattern = cnt;
            MODE_GRAY:   pattern = cnt ^ (cnt >> 1);
            MODE_SCAN:   pattern[pos] = 1'b1;
            default:     pattern = {LED_WIDTH{pwm_cnt < level}};
        endcase
        for (int i = 0; i < LED_WIDTH; i++) begin
            pattern_rev[i] = pattern[LED_WIDTH-1-i];
        end
    end

    // Registered outputs; step_tick lines up with the first cycle showing a new step
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            io_led_a  <= A_MASK;
            io_led_b  <= '0;
            tick_d1   <= 1'b0;
            step_tick <= 1'b0;
        end else begin
            io_led_a  <= pattern ^ A_MASK;
            io_led_b  <= pattern_rev;
            tick_d1   <= tick;
            step_tick <= tick_d1;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen against a step-index reference model
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       btn_reset;
    logic [1:0] mode;
    logic       pause;
    logic [7:0] io_led_a;
    logic [7:0] io_led_b;
    logic       step_tick;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .LED_WIDTH      (8),
        .PRESCALE_WIDTH (2),
        .PWM_WIDTH      (2),
        .INVERT_A       (1)
    ) dut (
        .clk       (clk),
        .btn_reset (btn_reset),
        .mode      (mode),
        .pause     (pause),
        .io_led_a  (io_led_a),
        .io_led_b  (io_led_b),
        .step_tick (step_tick)
    );

    int total = 0;
    int bad   = 0;

    // Model: active mode plus number of steps taken since that mode was loaded
    int       m_presc;
    int       m_pwm;
    int       m_k;
    int       m_mode;
    bit       m_td1;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_st;
    int       ticks_seen = 0;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [7:0] model_pattern();
        logic [7:0] c;
        int m;
        int p;
        case (m_mode)
            0: return 8'(m_k % 256);
            1: begin
                c = 8'(m_k % 256);
                return c ^ (c >> 1);
            end
            2: begin
                m = m_k % 14;
                p = (m <= 7) ? m : 14 - m;
                c = 8'h01;
                return c << p;
            end
            default: begin
                m = m_k % 6;
                p = (m <= 3) ? m : 6 - m;
                return (m_pwm < p) ? 8'hFF : 8'h00;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_pwm   = 0;
        m_k     = 0;
        m_mode  = 0;
        m_td1   = 0;
        exp_a   = 8'hFF;
        exp_b   = 8'h00;
        exp_st  = 1'b0;
    endtask

    task automatic cycle();
        logic [7:0] p;
        bit t;
        if (!btn_reset) begin
            model_reset();
        end else begin
            p      = model_pattern();
            exp_a  = ~p;
            exp_b  = rev8(p);
            exp_st = m_td1;
            t      = (m_presc == 3) && !pause;
            m_td1  = t;
            if (t) begin
                if (int'(mode) != m_mode) begin
                    m_mode = int'(mode);
                    m_k    = 0;
                end else begin
                    m_k++;
                end
            end
            if (!pause) m_presc = (m_presc + 1) % 4;
            m_pwm = (m_pwm + 1) % 4;
        end
        @(posedge clk);
        #1;
        chk("led_a", io_led_a, exp_a);
        chk("led_b", io_led_b, exp_b);
        chk("step_tick", step_tick, exp_st);
        if (step_tick === 1'b1) ticks_seen++;
    endtask

    task automatic run_steps(input int n);
        int start;
        int budget;
        start  = ticks_seen;
        budget = n * 4 + 8;
        for (int c = 0; c < budget && (ticks_seen - start) < n; c++) cycle();
        chk("step_budget", ticks_seen - start, n);
    endtask

    initial begin
        int on_cnt;
        btn_reset = 1'b0;
        mode      = 2'd0;
        pause     = 1'b0;
        model_reset();

        // Reset held across edges
        repeat (3) cycle();
        chk("rst_a", io_led_a, 8'hFF);
        chk("rst_b", io_led_b, 8'h00);
        btn_reset = 1'b1;

        // Binary counting, four steps
        run_steps(4);
        chk("bin4_a", io_led_a, 8'hFB);
        chk("bin4_b", io_led_b, 8'h20);

        // Scan sweep and end handling
        mode = 2'd2;
        run_steps(1);
        chk("scan_load_b", io_led_b, 8'h80);
        run_steps(7);
        chk("scan7_a", io_led_a, 8'h7F);
        run_steps(1);
        chk("scan8_a", io_led_a, 8'hBF);
        run_steps(6);
        chk("scan14_a", io_led_a, 8'hFE);
        chk("scan14_b", io_led_b, 8'h80);

        // Gray code up to wrap
        mode = 2'd1;
        run_steps(1);
        run_steps(255);
        chk("gray255_a", io_led_a, 8'h7F);
        chk("gray255_b", io_led_b, 8'h01);
        run_steps(1);
        chk("gray_wrap_a", io_led_a, 8'hFF);

        // Breathe duty at full level
        mode = 2'd3;
        run_steps(1);
        run_steps(3);
        on_cnt = (io_led_a === 8'h00) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (io_led_a === 8'h00) on_cnt++;
        end
        chk("breathe_duty", on_cnt, 3);
        run_steps(4);

        // Pause with a mode change hidden inside it
        mode = 2'd0;
        run_steps(1);
        run_steps(2);
        chk("pre_pause_a", io_led_a, 8'hFD);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) mode = 2'd2;
            cycle();
        end
        chk("paused_a", io_led_a, 8'hFD);
        chk("paused_b", io_led_b, 8'h40);
        pause = 1'b0;
        run_steps(1);
        chk("resume_a", io_led_a, 8'hFE);
        chk("resume_b", io_led_b, 8'h80);

        // Asynchronous reset pulse between edges mid-scan
        run_steps(3);
        #1 btn_reset = 1'b0;
        mode = 2'd0;
        #1;
        chk("async_rst_a", io_led_a, 8'hFF);
        chk("async_rst_b", io_led_b, 8'h00);
        chk("async_rst_st", step_tick, 1'b0);
        #1 btn_reset = 1'b1;
        model_reset();
        run_steps(1);
        chk("restart_a", io_led_a, 8'hFE);
        chk("restart_b", io_led_b, 8'h80);

        // Randomized mode and pause traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) pause = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
